// File: rtl/multicycle_controller_pkg.sv
// Shared opcode, func, ALU and state encodings for the multicycle MIPS controller,
// plus the bundle of control lines it drives into data_path.
package multicycle_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNC_JR  = 6'b001000;
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
  localparam logic [1:0] PC_SRC_REG_A  = 2'b10;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LW_WB    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_JAL      = 4'd10,
    S_JR       = 4'd11,
    S_I_EXEC   = 4'd12,
    S_I_WB     = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       jal_reg;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;
  } ctrl_t;

  function automatic logic opcode_known(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_J, OP_JAL, OP_ADDI, OP_SLTI, OP_ANDI: opcode_known = 1'b1;
      default:                                 opcode_known = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] i_type_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTI: i_type_alu_op = ALU_SLT;
      OP_ANDI: i_type_alu_op = ALU_AND;
      default: i_type_alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_func_decoder.sv
// Maps an R-type func field to its ALU code; jr is flagged apart because it
// takes its own state rather than an ALU operation.
module multicycle_controller_alu_func_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] alu_op,
  output logic       func_valid,
  output logic       func_is_jr
);

  always_comb begin
    alu_op     = ALU_ADD;
    func_valid = 1'b1;
    func_is_jr = 1'b0;
    case (func)
      FUNC_ADD: alu_op = ALU_ADD;
      FUNC_SUB: alu_op = ALU_SUB;
      FUNC_AND: alu_op = ALU_AND;
      FUNC_OR:  alu_op = ALU_OR;
      FUNC_SLT: alu_op = ALU_SLT;
      FUNC_JR: begin
        func_valid = 1'b0;
        func_is_jr = 1'b1;
      end
      default: func_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing one MIPS instruction over 3-5 cycles and driving every
// data_path control line; only the branch pc_write looks at the live ZERO flag.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       ZERO,
  output logic       pc_write,
  output logic       IR_write,
  output logic       I_or_D,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_dst,
  output logic       jal_reg,
  output logic       mem_to_reg,
  output logic       pc_to_reg,
  output logic       reg_write,
  output logic       alu_src_A,
  output logic [1:0] alu_src_B,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal
);

  state_t     state;
  state_t     next_state;
  logic       running;
  logic [2:0] r_alu_op;
  logic       func_valid;
  logic       func_is_jr;
  logic       op_unsupported;
  ctrl_t      ctrl;

  multicycle_controller_alu_func_decoder u_alu_func_decoder (
    .func       (func),
    .alu_op     (r_alu_op),
    .func_valid (func_valid),
    .func_is_jr (func_is_jr)
  );

  assign op_unsupported = !opcode_known(opcode) ||
                          ((opcode == OP_RTYPE) && !func_valid && !func_is_jr);

  // running stays low through the first edge after reset so FETCH is held one
  // full cycle before the sequence advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      running <= 1'b0;
    end else begin
      running <= 1'b1;
      if (running) state <= next_state;
    end
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        if (!op_unsupported) begin
          case (opcode)
            OP_RTYPE:                  next_state = func_is_jr ? S_JR : S_R_EXEC;
            OP_LW, OP_SW:              next_state = S_MEM_ADDR;
            OP_BEQ, OP_BNE:            next_state = S_BRANCH;
            OP_J:                      next_state = S_JUMP;
            OP_JAL:                    next_state = S_JAL;
            OP_ADDI, OP_SLTI, OP_ANDI: next_state = S_I_EXEC;
            default:                   next_state = S_FETCH;
          endcase
        end
      end
      S_MEM_ADDR: next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   next_state = S_LW_WB;
      S_R_EXEC:   next_state = S_R_WB;
      S_I_EXEC:   next_state = S_I_WB;
      default:    next_state = S_FETCH;
    endcase
  end

  // Everything is held at zero until running is set, so an aborted
  // instruction cannot leak a write strobe while rst is low.
  always_comb begin
    ctrl = '0;
    if (running) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.ir_write  = 1'b1;
          ctrl.alu_src_b = SRC_B_FOUR;
          ctrl.alu_op    = ALU_ADD;
          ctrl.pc_src    = PC_SRC_ALU;
          ctrl.pc_write  = 1'b1;
        end
        S_DECODE: begin
          ctrl.alu_src_b = SRC_B_IMM_SH;
          ctrl.alu_op    = ALU_ADD;
          ctrl.illegal   = op_unsupported;
        end
        S_R_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRC_B_REG;
          ctrl.alu_op    = r_alu_op;
        end
        S_R_WB: begin
          ctrl.reg_dst   = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        S_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRC_B_IMM;
          ctrl.alu_op    = ALU_ADD;
        end
        S_MEM_RD: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        S_LW_WB: begin
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
        end
        S_MEM_WR: begin
          ctrl.mem_write = 1'b1;
          ctrl.i_or_d    = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRC_B_REG;
          ctrl.alu_op    = ALU_SUB;
          ctrl.pc_src    = PC_SRC_ALUOUT;
          ctrl.pc_write  = (opcode == OP_BNE) ? ~ZERO : ZERO;
        end
        S_JUMP: begin
          ctrl.pc_src   = PC_SRC_JUMP;
          ctrl.pc_write = 1'b1;
        end
        S_JAL: begin
          ctrl.pc_src    = PC_SRC_JUMP;
          ctrl.pc_write  = 1'b1;
          ctrl.jal_reg   = 1'b1;
          ctrl.pc_to_reg = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        S_JR: begin
          ctrl.pc_src   = PC_SRC_REG_A;
          ctrl.pc_write = 1'b1;
        end
        S_I_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRC_B_IMM;
          ctrl.alu_op    = i_type_alu_op(opcode);
        end
        S_I_WB: ctrl.reg_write = 1'b1;
        default: ctrl = '0;
      endcase
    end
  end

  assign pc_write   = ctrl.pc_write;
  assign IR_write   = ctrl.ir_write;
  assign I_or_D     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign reg_dst    = ctrl.reg_dst;
  assign jal_reg    = ctrl.jal_reg;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign pc_to_reg  = ctrl.pc_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_A  = ctrl.alu_src_a;
  assign alu_src_B  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign illegal    = ctrl.illegal;

endmodule
